// File: rtl/marx_arb_pkg.sv
// Shared types and helpers for the MARX core arbiter: default widths,
// the core index type, the downstream payload bundle and the round-robin pick.
package marx_arb_pkg;

  localparam int DEF_N_CPUS       = 4;
  localparam int DEF_MAX_INFLIGHT = 4;
  localparam int DEF_WOP_CPU      = 6;
  localparam int DEF_WAPUTYPE     = 3;
  localparam int DEF_NDSFLAGS_CPU = 15;
  localparam int DEF_NUSFLAGS_CPU = 5;
  localparam int DEF_WARG         = 32;
  localparam int DEF_NARGS_CPU    = 3;
  localparam int DEF_WRESULT      = 32;

  localparam int CORE_ID_W = (DEF_N_CPUS > 1) ? $clog2(DEF_N_CPUS) : 1;

  typedef logic [CORE_ID_W-1:0] core_id_t;

  // Everything that travels downstream with one operation.
  typedef struct packed {
    logic [DEF_WAPUTYPE-1:0]                  kind;
    logic [DEF_NARGS_CPU-1:0][DEF_WARG-1:0]   operands;
    logic [DEF_WOP_CPU-1:0]                   op;
    logic [DEF_NDSFLAGS_CPU-1:0]              flags;
  } marx_payload_t;

  // First requester found searching last+1, last+2, ... modulo N; returns
  // last when nobody requests (the caller gates the request anyway).
  function automatic core_id_t rr_pick(input logic [DEF_N_CPUS-1:0] req,
                                       input core_id_t last);
    core_id_t pick;
    logic     found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= DEF_N_CPUS; i++) begin
      int idx;
      idx = (int'(last) + i) % DEF_N_CPUS;
      if (!found && req[idx]) begin
        pick  = core_id_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/marx_tag_fifo.sv
// In-order FIFO of core IDs: one entry per operation accepted by the shared
// unit and not yet answered. Depth need not be a power of two.
module marx_tag_fifo
  import marx_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_INFLIGHT
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push,
  input  core_id_t push_id,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output core_id_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  core_id_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr_q];

  // Tag storage write.
  // NOTE: storage is not reset; count and pointers alone decide which entries
  // are live, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= push_id;
  end

  // Pointer and occupancy update; push and pop together leave count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/marx_core_arbiter.sv
// Shares one MARX-attached unit between N_CPUS cores: round-robin grant with
// a lock that holds a stalled grant, zero-latency payload mux, and an in-order
// tag FIFO that routes each result back to the core that issued it.
// Width parameters must agree with the marx_arb_pkg defaults.
module marx_core_arbiter
  import marx_arb_pkg::*;
#(
  parameter int N_CPUS       = DEF_N_CPUS,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
  parameter int WOP_CPU      = DEF_WOP_CPU,
  parameter int WAPUTYPE     = DEF_WAPUTYPE,
  parameter int NDSFLAGS_CPU = DEF_NDSFLAGS_CPU,
  parameter int NUSFLAGS_CPU = DEF_NUSFLAGS_CPU,
  parameter int WARG         = DEF_WARG,
  parameter int NARGS_CPU    = DEF_NARGS_CPU,
  parameter int WRESULT      = DEF_WRESULT
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [N_CPUS-1:0]                      core_req_i,
  output logic [N_CPUS-1:0]                      core_ack_o,
  input  logic [N_CPUS-1:0][WAPUTYPE-1:0]        core_type_i,
  input  logic [N_CPUS-1:0][NARGS_CPU-1:0][WARG-1:0] core_operands_i,
  input  logic [N_CPUS-1:0][WOP_CPU-1:0]         core_op_i,
  input  logic [N_CPUS-1:0][NDSFLAGS_CPU-1:0]    core_flags_i,
  output logic [N_CPUS-1:0]                      core_valid_o,
  input  logic [N_CPUS-1:0]                      core_ready_i,
  output logic [WRESULT-1:0]                     core_result_o,
  output logic [NUSFLAGS_CPU-1:0]                core_flags_o,
  output logic                                   apu_req_o,
  input  logic                                   apu_ack_i,
  output logic [WAPUTYPE-1:0]                    apu_type_o,
  output logic [NARGS_CPU-1:0][WARG-1:0]         apu_operands_o,
  output logic [WOP_CPU-1:0]                     apu_op_o,
  output logic [NDSFLAGS_CPU-1:0]                apu_flags_o,
  input  logic                                   apu_valid_i,
  output logic                                   apu_ready_o,
  input  logic [WRESULT-1:0]                     apu_result_i,
  input  logic [NUSFLAGS_CPU-1:0]                apu_flags_i
);

  core_id_t      rr_q;
  core_id_t      sel_q;
  logic          lock_q;
  core_id_t      sel;
  core_id_t      head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  marx_payload_t sel_payload;

  // Grant selection, downstream mux/handshake and upstream routing.
  // NOTE: every output of this block gets a default first, so no path through
  // it can leave a value unassigned and infer a latch.
  always_comb begin
    core_ack_o     = '0;
    core_valid_o   = '0;
    sel            = lock_q ? sel_q : rr_pick(core_req_i, rr_q);
    // Request is forced low during reset so the unit sees nothing stale.
    apu_req_o      = core_req_i[sel] & ~full & ~rst_i;
    apu_type_o     = core_type_i[sel];
    apu_operands_o = core_operands_i[sel];
    apu_op_o       = core_op_i[sel];
    apu_flags_o    = core_flags_i[sel];
    push           = apu_req_o & apu_ack_i;
    if (push) core_ack_o[sel] = 1'b1;
    apu_ready_o    = core_ready_i[head] & ~empty;
    if (apu_valid_i && !empty) core_valid_o[head] = 1'b1;
    pop            = apu_valid_i & apu_ready_o;
    core_result_o  = apu_result_i;
    core_flags_o   = apu_flags_i;
  end

  // Round-robin pointer and stall lock: a request that is not acked pins the
  // grant to that core until the unit takes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= core_id_t'(N_CPUS - 1);
      sel_q  <= '0;
      lock_q <= 1'b0;
    end else if (push) begin
      rr_q   <= sel;
      lock_q <= 1'b0;
    end else if (apu_req_o) begin
      sel_q  <= sel;
      lock_q <= 1'b1;
    end
  end

  marx_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push),
    .push_id (sel),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign sel_payload = {apu_type_o, apu_operands_o, apu_op_o, apu_flags_o};

  a_ack_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(core_ack_o));
  a_valid_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(core_valid_o));
  a_payload_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    lock_q |-> $stable(sel_payload));
  a_no_valid_when_empty : assert property (@(posedge clk_i) disable iff (rst_i)
    apu_valid_i |-> !empty);

endmodule

// File: tb/tb_marx_core_arbiter.sv
// Self-checking bench for marx_core_arbiter (MAX_INFLIGHT=2): directed
// scenarios followed by constrained-random traffic, all checked against a
// queue-based reference model of the arbitration and tag-return rules.
module tb_marx_core_arbiter;

  localparam int N     = 4;
  localparam int MAXI  = 2;
  localparam int WOP   = 6;
  localparam int WTY   = 3;
  localparam int NDS   = 15;
  localparam int NUS   = 5;
  localparam int WARG  = 32;
  localparam int NARGS = 3;
  localparam int WRES  = 32;

  logic                           clk = 1'b0;
  logic                           rst_i;
  logic [N-1:0]                   core_req;
  logic [N-1:0]                   core_ack;
  logic [N-1:0][WTY-1:0]          core_type;
  logic [N-1:0][NARGS-1:0][WARG-1:0] core_operands;
  logic [N-1:0][WOP-1:0]          core_op;
  logic [N-1:0][NDS-1:0]          core_flags_ds;
  logic [N-1:0]                   core_valid;
  logic [N-1:0]                   core_ready;
  logic [WRES-1:0]                core_result;
  logic [NUS-1:0]                 core_flags_us;
  logic                           apu_req;
  logic                           apu_ack;
  logic [WTY-1:0]                 apu_type;
  logic [NARGS-1:0][WARG-1:0]     apu_operands;
  logic [WOP-1:0]                 apu_op;
  logic [NDS-1:0]                 apu_flags_ds;
  logic                           apu_valid;
  logic                           apu_ready;
  logic [WRES-1:0]                apu_result;
  logic [NUS-1:0]                 apu_flags_us;

  always #5 clk = ~clk;

  marx_core_arbiter #(
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .core_req_i      (core_req),
    .core_ack_o      (core_ack),
    .core_type_i     (core_type),
    .core_operands_i (core_operands),
    .core_op_i       (core_op),
    .core_flags_i    (core_flags_ds),
    .core_valid_o    (core_valid),
    .core_ready_i    (core_ready),
    .core_result_o   (core_result),
    .core_flags_o    (core_flags_us),
    .apu_req_o       (apu_req),
    .apu_ack_i       (apu_ack),
    .apu_type_o      (apu_type),
    .apu_operands_o  (apu_operands),
    .apu_op_o        (apu_op),
    .apu_flags_o     (apu_flags_ds),
    .apu_valid_i     (apu_valid),
    .apu_ready_o     (apu_ready),
    .apu_result_i    (apu_result),
    .apu_flags_i     (apu_flags_us)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: list of outstanding issuers, last granted core, lock.
  int q[$];
  int m_rr;
  bit m_lock;
  int m_lock_core;

  // Expectations for the current cycle.
  int           e_sel;
  bit           e_req;
  logic [N-1:0] e_ack;
  logic [N-1:0] e_valid;
  bit           e_ready;
  bit           e_pop;

  logic [WOP-1:0] saved_op;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rr        = N - 1;
    m_lock      = 1'b0;
    m_lock_core = 0;
  endtask

  task automatic new_payload(input int c);
    core_type[c]     = WTY'($urandom);
    core_op[c]       = WOP'($urandom);
    core_flags_ds[c] = NDS'($urandom);
    for (int a = 0; a < NARGS; a++) core_operands[c][a] = $urandom;
  endtask

  // Mid-cycle: derive expectations from the model and compare all outputs.
  task automatic settle();
    @(negedge clk);
    e_sel = -1;
    if (m_lock) e_sel = m_lock_core;
    else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (e_sel < 0 && core_req[c]) e_sel = c;
      end
    end
    e_req   = !rst_i && (e_sel >= 0) && core_req[e_sel] && (q.size() < MAXI);
    e_ack   = '0;
    if (e_req && apu_ack) e_ack[e_sel] = 1'b1;
    e_valid = '0;
    e_ready = 1'b0;
    if (!rst_i && q.size() > 0) begin
      if (apu_valid) e_valid[q[0]] = 1'b1;
      e_ready = core_ready[q[0]];
    end
    e_pop = apu_valid && e_ready;
    check("apu_req", apu_req, e_req);
    check("core_ack", core_ack, e_ack);
    check("core_valid", core_valid, e_valid);
    check("apu_ready", apu_ready, e_ready);
    check("core_result", core_result, apu_result);
    check("core_flags_up", core_flags_us, apu_flags_us);
    if (e_req) begin
      check("apu_op", apu_op, core_op[e_sel]);
      check("apu_type", apu_type, core_type[e_sel]);
      check("apu_operands", apu_operands, core_operands[e_sel]);
      check("apu_flags", apu_flags_ds, core_flags_ds[e_sel]);
    end
  endtask

  // Clock edge: advance the model with this cycle's handshakes.
  task automatic edge_step();
    @(posedge clk);
    if (!rst_i) begin
      if (e_pop) void'(q.pop_front());
      if (e_req && apu_ack) begin
        q.push_back(e_sel);
        m_rr   = e_sel;
        m_lock = 1'b0;
      end else if (e_req) begin
        m_lock      = 1'b1;
        m_lock_core = e_sel;
      end
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    edge_step();
  endtask

  task automatic reset_pulse();
    rst_i     = 1'b1;
    apu_valid = 1'b0;
    model_reset();
    cycle();
    rst_i = 1'b0;
  endtask

  task automatic drain();
    int budget;
    core_req   = '0;
    apu_ack    = 1'b0;
    core_ready = '1;
    budget     = 0;
    while (q.size() > 0 && budget < 20) begin
      apu_valid  = 1'b1;
      apu_result = $urandom;
      cycle();
      budget++;
    end
    apu_valid = 1'b0;
    check("drain_done", q.size(), 0);
  endtask

  initial begin
    rst_i        = 1'b1;
    core_req     = '0;
    core_ready   = '0;
    apu_ack      = 1'b0;
    apu_valid    = 1'b0;
    apu_result   = '0;
    apu_flags_us = '0;
    for (int c = 0; c < N; c++) new_payload(c);
    model_reset();
    #1;
    settle();
    check("rst_ack", core_ack, 0);
    check("rst_valid", core_valid, 0);
    check("rst_req", apu_req, 0);
    check("rst_ready", apu_ready, 0);
    edge_step();
    rst_i = 1'b0;

    // 1: lone core 2, acked immediately, result routed back to it.
    new_payload(2);
    core_req = 4'b0100;
    apu_ack  = 1'b1;
    settle();
    check("t1_ack", core_ack, 4'b0100);
    edge_step();
    core_req     = '0;
    apu_ack      = 1'b0;
    apu_valid    = 1'b1;
    apu_result   = 32'hDEADBEEF;
    apu_flags_us = 5'h15;
    core_ready   = 4'b0100;
    settle();
    check("t1_valid", core_valid, 4'b0100);
    check("t1_result", core_result, 32'hDEADBEEF);
    edge_step();
    apu_valid = 1'b0;

    // 2: all cores requesting, unit acks every cycle, results one behind.
    reset_pulse();
    core_req   = 4'b1111;
    apu_ack    = 1'b1;
    core_ready = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      logic [N-1:0] exp_g;
      logic [N-1:0] exp_v;
      exp_g      = N'(1) << (g % N);
      exp_v      = N'(1) << ((g + N - 1) % N);
      apu_valid  = (g > 0);
      apu_result = $urandom;
      settle();
      check("t2_grant", core_ack, exp_g);
      if (g > 0) check("t2_valid", core_valid, exp_v);
      edge_step();
      new_payload(g % N);
    end
    drain();

    // 3: cores 1 and 3 request, ack withheld 3 cycles; grant stays on core 1.
    new_payload(1);
    new_payload(3);
    saved_op = core_op[1];
    core_req = 4'b1010;
    apu_ack  = 1'b0;
    for (int h = 0; h < 3; h++) begin
      settle();
      check("t3_hold_req", apu_req, 1);
      check("t3_hold_op", apu_op, saved_op);
      edge_step();
    end
    apu_ack = 1'b1;
    settle();
    check("t3_ack1", core_ack, 4'b0010);
    edge_step();
    core_req[1] = 1'b0;
    settle();
    check("t3_ack3", core_ack, 4'b1000);
    edge_step();
    drain();

    // 3b: core 3 stalled alone, then core 1 (higher rr priority) joins.
    new_payload(3);
    saved_op = core_op[3];
    core_req = 4'b1000;
    apu_ack  = 1'b0;
    cycle();
    new_payload(1);
    core_req = 4'b1010;
    settle();
    check("t3b_locked_op", apu_op, saved_op);
    edge_step();
    apu_ack = 1'b1;
    settle();
    check("t3b_ack3", core_ack, 4'b1000);
    edge_step();
    core_req = 4'b0010;
    settle();
    check("t3b_ack1", core_ack, 4'b0010);
    edge_step();
    drain();

    // 4: fill to MAX_INFLIGHT, then request is gated until a pop.
    reset_pulse();
    core_req = 4'b1111;
    apu_ack  = 1'b1;
    cycle();
    cycle();
    settle();
    check("t4_full_req", apu_req, 0);
    check("t4_full_ack", core_ack, 0);
    edge_step();
    apu_valid  = 1'b1;
    core_ready = 4'b1111;
    settle();
    check("t4_pop_still_full", apu_req, 0);
    check("t4_pop_valid", core_valid, 4'b0001);
    edge_step();
    apu_valid = 1'b0;
    settle();
    check("t4_resume_ack", core_ack, 4'b0100);
    edge_step();

    // 5: head core not ready blocks; then push and pop together at count 1.
    core_req   = '0;
    apu_ack    = 1'b0;
    apu_valid  = 1'b1;
    core_ready = 4'b1101;
    settle();
    check("t5_blocked_ready", apu_ready, 0);
    check("t5_blocked_valid", core_valid, 4'b0010);
    edge_step();
    core_ready = 4'b1111;
    cycle();
    new_payload(0);
    core_req = 4'b0001;
    apu_ack  = 1'b1;
    settle();
    check("t5_pushpop_ack", core_ack, 4'b0001);
    check("t5_pushpop_valid", core_valid, 4'b0100);
    edge_step();
    core_req   = '0;
    apu_ack    = 1'b0;
    core_ready = 4'b1110;
    settle();
    check("t5_core0_block", apu_ready, 0);
    check("t5_core0_valid", core_valid, 4'b0001);
    edge_step();
    drain();

    // 6: reset with operations in flight; core 0 wins first afterwards.
    core_req = 4'b0110;
    apu_ack  = 1'b1;
    cycle();
    cycle();
    rst_i    = 1'b1;
    model_reset();
    core_req = 4'b1111;
    settle();
    check("t6_rst_req", apu_req, 0);
    check("t6_rst_ack", core_ack, 0);
    check("t6_rst_valid", core_valid, 0);
    check("t6_rst_ready", apu_ready, 0);
    edge_step();
    rst_i = 1'b0;
    settle();
    check("t6_first_grant", core_ack, 4'b0001);
    edge_step();
    drain();

    // Random traffic; cores hold requests and payload until acked.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) reset_pulse();
      for (int c = 0; c < N; c++) begin
        if (e_ack[c]) begin
          core_req[c] = 1'($urandom);
          new_payload(c);
        end else if (!core_req[c] && ($urandom % 3 == 0)) begin
          core_req[c] = 1'b1;
          new_payload(c);
        end
      end
      apu_ack      = 1'($urandom);
      apu_valid    = (q.size() > 0) && ($urandom % 2 == 0);
      apu_result   = $urandom;
      apu_flags_us = NUS'($urandom);
      core_ready   = N'($urandom);
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
